gyro_rate_integrator: RTL and testbench
=======================================

Name: gyro_rate_integrator

Overview:
- Consumes the three signed 16-bit angular-rate words from the PmodGYRO controller (data_x/y/z) and turns them into calibrated, integrated angle estimates.
- On reset it averages 2^CALIB_LOG2 samples per axis to learn the zero-rate bias. It then subtracts that bias, applies a deadband and accumulates into saturating per-axis integrators.
- Sits directly downstream of the gyro controller. Its outputs feed LED/display logic and the game/control logic.

Parameters:
- CALIB_LOG2, 4, log2 of the calibration sample count (16 samples).
- DEADBAND, 8, bias-corrected magnitudes <= DEADBAND are treated as 0.
- ACC_W, 32, signed integrator width per axis (>= 20).
- SHIFT, 4, arithmetic right shift applied to the integrator to form the angle output.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- sample_valid  in  1  one-cycle pulse: data_x/y/z hold a new coherent sample.
- data_x  in  16  signed X rate.
- data_y  in  16  signed Y rate.
- data_z  in  16  signed Z rate.
- recal  in  1  pulse: discard bias and angles, restart calibration.
- zero  in  1  pulse: clear integrators only; bias is kept.
- calibrated  out  1  high while in RUN.
- out_valid  out  1  one-cycle pulse when the angle outputs update.
- angle_x  out  16  signed integrated X angle.
- angle_y  out  16  signed integrated Y angle.
- angle_z  out  16  signed integrated Z angle.

Behaviour:
- Reset values:
  - state = CAL; sample count = 0.
  - bias sums, bias registers and integrators = 0.
  - calibrated = 0, out_valid = 0, angle_x/y/z = 0.
- Reset mid-pipeline drops all in-flight samples.
- FSM states: CAL, RUN.
- CAL:
  - Each sample_valid adds the sign-extended sample into the per-axis sum (width 16+CALIB_LOG2) and increments count.
  - On the 2^CALIB_LOG2-th sample: bias = sum >>> CALIB_LOG2 (arithmetic, truncates toward -inf); the next cycle enters RUN.
  - calibrated rises in the same cycle the state becomes RUN.
  - out_valid is never asserted in CAL; angles stay 0.
- RUN pipeline, sample_valid at cycle t:
  - Stage 1 (t+1): corr = sample - bias, 17-bit signed. If |corr| <= DEADBAND then corr = 0.
  - Stage 2 (t+2): acc = acc + sign-extended corr, saturating at ACC_W signed min/max (no wrap).
  - angle = sat16(acc >>> SHIFT), clamped to [-32768, 32767].
  - out_valid pulses at t+2, coincident with the new angle values. Latency is exactly 2 cycles.
- Throughput: sample_valid may arrive every cycle; each sample produces exactly one out_valid.
- recal:
  - Next cycle: state = CAL, count/sums/bias/integrators/angles = 0, calibrated = 0.
  - In-flight pipeline samples are dropped with no out_valid.
  - recal with a simultaneous sample_valid: recal wins and the sample is discarded, not counted toward calibration.
- zero:
  - In RUN: integrators and angles = 0 next cycle; in-flight samples are dropped with no out_valid.
  - A simultaneous sample_valid is also dropped.
  - Ignored in CAL.
- recal and zero together: recal wins.
- Inputs are sampled only on the sample_valid cycle; data changes at other times are ignored.

Decomposition:
- Shared package (gyro_pkg):
  - AXIS_W = 16, CORR_W = 17.
  - State enum {CAL, RUN}.
  - Saturation helper functions: ACC_W clamp and 16-bit clamp.
- Sub-module gyro_axis_channel, instantiated 3 times. Each instance holds one axis's bias sum, bias, deadband stage, integrator and angle register.
- The top holds the FSM, sample counter and out_valid pipeline, and broadcasts control strobes (accumulate_bias, latch_bias, run_sample, clear_all, clear_acc) to the channels.

Test Plan:
- Calibration: 16 samples with x=100, y=-50, z=0 -> calibrated rises after the 16th. Bias x=100, y=-50, z=0; no out_valid seen during CAL.
- Integration: after calibration, 16 back-to-back samples x=164 -> 16 out_valid pulses, each 2 cycles after its sample; final angle_x = 64 (acc 1024 >>> 4).
- Deadband/rounding:
  - Calibrate with x alternating 0,1 -> bias 0.
  - Then x=5 (x8) -> angle_x stays 0.
  - Then x=-9 (x16) -> angle_x = -9.
- Saturation: bench with ACC_W=20, bias 0, repeated x=32767 -> acc clamps at 524287 and angle_x holds 32767; then x=-32768 brings it down without wrap.
- zero/recal:
  - zero pulsed together with a sample -> no out_valid for that sample; angles become 0; calibrated stays 1.
  - recal -> calibrated falls next cycle and 16 new samples are required.
- Async reset asserted mid-pipeline, between clock edges -> all outputs are 0 immediately, and no stale out_valid appears after release.

Source files
------------

// File: rtl/gyro_pkg.sv
// Shared widths, FSM state type and saturation helpers for the gyro rate integrator.
package gyro_pkg;

  localparam int AXIS_W = 16;
  localparam int CORR_W = 17;
  localparam int WIDE_W = 64;

  typedef enum logic [0:0] {
    CAL = 1'b0,
    RUN = 1'b1
  } state_e;

  // Clamp a wide signed value into the signed range of an acc_w-bit integrator.
  function automatic logic signed [WIDE_W-1:0] sat_acc(input logic signed [WIDE_W-1:0] v,
                                                       input int acc_w);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  function automatic logic signed [AXIS_W-1:0] sat16(input logic signed [WIDE_W-1:0] v);
    if (v > 64'sd32767)       return 16'sh7fff;
    else if (v < -64'sd32768) return 16'sh8000;
    else                      return v[AXIS_W-1:0];
  endfunction

endpackage

// File: rtl/gyro_axis_channel.sv
// One axis: calibration sum and bias, deadband stage, saturating integrator and angle register.
module gyro_axis_channel
  import gyro_pkg::*;
#(
  parameter int CALIB_LOG2 = 4,
  parameter int DEADBAND   = 8,
  parameter int ACC_W      = 32,
  parameter int SHIFT      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [AXIS_W-1:0] i_data,
  input  logic                     i_accumulate_bias,
  input  logic                     i_latch_bias,
  input  logic                     i_run_sample,
  input  logic                     i_acc_update,
  input  logic                     i_clear_all,
  input  logic                     i_clear_acc,
  output logic signed [AXIS_W-1:0] o_angle
);

  localparam int SUM_W = AXIS_W + CALIB_LOG2;
  localparam logic signed [CORR_W-1:0] DB_HI = CORR_W'(DEADBAND);
  localparam logic signed [CORR_W-1:0] DB_LO = -DB_HI;

  logic signed [SUM_W-1:0]  r_sum;
  logic signed [AXIS_W-1:0] r_bias;
  logic signed [CORR_W-1:0] r_corr;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [AXIS_W-1:0] r_angle;

  logic signed [SUM_W-1:0]  w_sum_next;
  logic signed [CORR_W-1:0] w_corr_raw;
  logic signed [CORR_W-1:0] w_corr;
  logic signed [WIDE_W-1:0] w_acc_sum;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [WIDE_W-1:0] w_acc_next_wide;

  assign w_sum_next      = r_sum + SUM_W'(i_data);
  assign w_corr_raw      = CORR_W'(i_data) - CORR_W'(r_bias);
  assign w_corr          = ((w_corr_raw >= DB_LO) && (w_corr_raw <= DB_HI)) ? '0 : w_corr_raw;
  assign w_acc_sum       = WIDE_W'(r_acc) + WIDE_W'(r_corr);
  assign w_acc_next      = ACC_W'(sat_acc(w_acc_sum, ACC_W));
  assign w_acc_next_wide = WIDE_W'(w_acc_next);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_bias  <= '0;
      r_corr  <= '0;
      r_acc   <= '0;
      r_angle <= '0;
    end else if (i_clear_all) begin
      r_sum   <= '0;
      r_bias  <= '0;
      r_corr  <= '0;
      r_acc   <= '0;
      r_angle <= '0;
    end else begin
      if (i_accumulate_bias) r_sum <= w_sum_next;
      // The sum includes the final sample, so the bias is taken from the next-sum value.
      if (i_latch_bias)      r_bias <= AXIS_W'(w_sum_next >>> CALIB_LOG2);
      if (i_clear_acc) begin
        r_corr  <= '0;
        r_acc   <= '0;
        r_angle <= '0;
      end else begin
        if (i_run_sample) r_corr <= w_corr;
        if (i_acc_update) begin
          r_acc   <= w_acc_next;
          r_angle <= sat16(w_acc_next_wide >>> SHIFT);
        end
      end
    end
  end

  assign o_angle = r_angle;

endmodule

// File: rtl/gyro_rate_integrator.sv
// Top: calibration/run FSM, sample counter and valid pipeline driving three axis channels.
module gyro_rate_integrator
  import gyro_pkg::*;
#(
  parameter int CALIB_LOG2 = 4,
  parameter int DEADBAND   = 8,
  parameter int ACC_W      = 32,
  parameter int SHIFT      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [AXIS_W-1:0] data_x,
  input  logic signed [AXIS_W-1:0] data_y,
  input  logic signed [AXIS_W-1:0] data_z,
  input  logic                     recal,
  input  logic                     zero,
  output logic                     calibrated,
  output logic                     out_valid,
  output logic signed [AXIS_W-1:0] angle_x,
  output logic signed [AXIS_W-1:0] angle_y,
  output logic signed [AXIS_W-1:0] angle_z
);

  state_e                r_state;
  logic [CALIB_LOG2-1:0] r_count;
  logic                  r_s1_valid;
  logic                  r_out_valid;

  logic w_clear_all;
  logic w_clear_acc;
  logic w_accumulate_bias;
  logic w_latch_bias;
  logic w_run_sample;
  logic w_acc_update;

  // recal dominates zero and any coincident sample; zero only matters once running.
  assign w_clear_all       = recal;
  assign w_clear_acc       = zero && (r_state == RUN);
  assign w_accumulate_bias = sample_valid && (r_state == CAL) && !w_clear_all;
  assign w_latch_bias      = w_accumulate_bias && (r_count == '1);
  assign w_run_sample      = sample_valid && (r_state == RUN) && !w_clear_all && !w_clear_acc;
  assign w_acc_update      = r_s1_valid && !w_clear_all && !w_clear_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= CAL;
      r_count     <= '0;
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_s1_valid  <= w_run_sample;
      r_out_valid <= w_acc_update;
      if (w_clear_all) begin
        r_state <= CAL;
        r_count <= '0;
      end else if (w_accumulate_bias) begin
        r_count <= r_count + 1'b1;
        if (w_latch_bias) r_state <= RUN;
      end
    end
  end

  assign calibrated = (r_state == RUN);
  assign out_valid  = r_out_valid;

  gyro_axis_channel #(
    .CALIB_LOG2(CALIB_LOG2), .DEADBAND(DEADBAND), .ACC_W(ACC_W), .SHIFT(SHIFT)
  ) u_ch_x (
    .clk(clk), .rst(rst), .i_data(data_x),
    .i_accumulate_bias(w_accumulate_bias), .i_latch_bias(w_latch_bias),
    .i_run_sample(w_run_sample), .i_acc_update(w_acc_update),
    .i_clear_all(w_clear_all), .i_clear_acc(w_clear_acc), .o_angle(angle_x)
  );

  gyro_axis_channel #(
    .CALIB_LOG2(CALIB_LOG2), .DEADBAND(DEADBAND), .ACC_W(ACC_W), .SHIFT(SHIFT)
  ) u_ch_y (
    .clk(clk), .rst(rst), .i_data(data_y),
    .i_accumulate_bias(w_accumulate_bias), .i_latch_bias(w_latch_bias),
    .i_run_sample(w_run_sample), .i_acc_update(w_acc_update),
    .i_clear_all(w_clear_all), .i_clear_acc(w_clear_acc), .o_angle(angle_y)
  );

  gyro_axis_channel #(
    .CALIB_LOG2(CALIB_LOG2), .DEADBAND(DEADBAND), .ACC_W(ACC_W), .SHIFT(SHIFT)
  ) u_ch_z (
    .clk(clk), .rst(rst), .i_data(data_z),
    .i_accumulate_bias(w_accumulate_bias), .i_latch_bias(w_latch_bias),
    .i_run_sample(w_run_sample), .i_acc_update(w_acc_update),
    .i_clear_all(w_clear_all), .i_clear_acc(w_clear_acc), .o_angle(angle_z)
  );

endmodule

// File: tb/tb_gyro_rate_integrator.sv
// Directed bench for gyro_rate_integrator (ACC_W=20 so saturation is reachable quickly).
module tb_gyro_rate_integrator;

  logic               clk;
  logic               rst;
  logic               sample_valid;
  logic signed [15:0] data_x, data_y, data_z;
  logic               recal, zero;
  logic               calibrated, out_valid;
  logic signed [15:0] angle_x, angle_y, angle_z;

  int checks = 0;
  int errors = 0;

  gyro_rate_integrator #(
    .CALIB_LOG2(4), .DEADBAND(8), .ACC_W(20), .SHIFT(4)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .data_x(data_x), .data_y(data_y), .data_z(data_z),
    .recal(recal), .zero(zero),
    .calibrated(calibrated), .out_valid(out_valid),
    .angle_x(angle_x), .angle_y(angle_y), .angle_z(angle_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic sv;
    int   x, y, z;
    logic ov;
    int   ax, ay, az;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input int x, input int y, input int z);
    sample_valid = sv;
    data_x = 16'(x);
    data_y = 16'(y);
    data_z = 16'(z);
  endtask

  task automatic check_angles(input string tag, input int ax, input int ay, input int az);
    check({tag, " angle_x"}, int'(angle_x), ax);
    check({tag, " angle_y"}, int'(angle_y), ay);
    check({tag, " angle_z"}, int'(angle_z), az);
  endtask

  // 16 calibration samples; even-indexed samples use x0/y0, odd ones x1/y1.
  task automatic calibrate(input string tag, input int x0, input int x1,
                           input int y0, input int y1, input int z);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i % 2 == 0) ? x0 : x1, (i % 2 == 0) ? y0 : y1, z);
      tick;
      check({tag, " out_valid in CAL"}, int'(out_valid), 0);
      check({tag, " calibrated"}, int'(calibrated), (i == 15) ? 1 : 0);
    end
    drive(1'b0, 0, 0, 0);
    check_angles({tag, " cal"}, 0, 0, 0);
  endtask

  // n back-to-back samples then two flush cycles; out_valid must trail each sample by two edges.
  task automatic run_stream(input string tag, input int n, input int x, input int y, input int z);
    for (int k = 0; k < n + 2; k++) begin
      drive(k < n, x, y, z);
      tick;
      check({tag, " out_valid"}, int'(out_valid), (k >= 1 && k <= n) ? 1 : 0);
    end
    drive(1'b0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    recal = 1'b0;
    zero = 1'b0;
    drive(1'b0, 0, 0, 0);

    for (int k = 0; k < 19; k++) begin
      automatic int done = (k > 16) ? 16 : k;
      vecs[k].sv = (k < 16);
      vecs[k].x  = (k == 18) ? 12345 : 164;
      vecs[k].y  = (k == 18) ? -999 : -114;
      vecs[k].z  = (k == 18) ? 777 : 16;
      vecs[k].ov = (k >= 1 && k <= 16);
      vecs[k].ax = 4 * done;
      vecs[k].ay = -4 * done;
      vecs[k].az = done;
    end

    // Reset state
    tick;
    tick;
    check("reset calibrated", int'(calibrated), 0);
    check("reset out_valid", int'(out_valid), 0);
    check_angles("reset", 0, 0, 0);
    rst = 1'b0;

    // Calibration: bias x=100, y=-50, z=0
    calibrate("cal1", 100, 100, -50, -50, 0);
    run_stream("bias-only", 1, 100, -50, 0);
    check_angles("bias-only", 0, 0, 0);

    // Integration: corr x=+64, y=-64, z=+16 per sample
    for (int k = 0; k < 19; k++) begin
      drive(vecs[k].sv, vecs[k].x, vecs[k].y, vecs[k].z);
      tick;
      check($sformatf("vec%0d out_valid", k), int'(out_valid), int'(vecs[k].ov));
      check_angles($sformatf("vec%0d", k), vecs[k].ax, vecs[k].ay, vecs[k].az);
    end
    drive(1'b0, 0, 0, 0);
    check("integrate final angle_x", int'(angle_x), 64);

    // zero with a sample in flight, then zero with a coincident sample
    drive(1'b1, 164, -50, 0);
    tick;
    drive(1'b0, 0, 0, 0);
    zero = 1'b1;
    tick;
    zero = 1'b0;
    check("zero inflight out_valid", int'(out_valid), 0);
    check("zero calibrated", int'(calibrated), 1);
    check_angles("zero", 0, 0, 0);
    tick;
    check("zero inflight late out_valid", int'(out_valid), 0);
    drive(1'b1, 164, -50, 0);
    zero = 1'b1;
    tick;
    zero = 1'b0;
    drive(1'b0, 0, 0, 0);
    check("zero+sample out_valid", int'(out_valid), 0);
    tick;
    check("zero+sample out_valid t+2", int'(out_valid), 0);
    tick;
    check("zero+sample out_valid t+3", int'(out_valid), 0);
    check_angles("zero+sample", 0, 0, 0);

    // recal (with zero and a sample) from a nonzero angle
    run_stream("pre-recal", 1, 164, -50, 0);
    check("pre-recal angle_x", int'(angle_x), 4);
    drive(1'b1, 500, 500, 500);
    recal = 1'b1;
    zero = 1'b1;
    tick;
    recal = 1'b0;
    zero = 1'b0;
    drive(1'b0, 0, 0, 0);
    check("recal calibrated", int'(calibrated), 0);
    check("recal out_valid", int'(out_valid), 0);
    check_angles("recal", 0, 0, 0);
    tick;
    check("recal inflight out_valid", int'(out_valid), 0);

    // Recalibrate: x alternating 0,1 -> bias 0; y alternating 0,-1 -> bias -1 (floor)
    calibrate("cal2", 0, 1, 0, -1, 0);

    // Deadband: x corr 5, y corr 1, z corr 8 -> all suppressed
    run_stream("deadband in", 8, 5, 0, 8);
    check_angles("deadband in", 0, 0, 0);
    // Just outside the band: corr -9, -9, +9 over 16 samples -> +/-144 >>> 4
    run_stream("deadband out", 16, -9, -10, 9);
    check_angles("deadband out", -9, -9, 9);

    // Saturation at ACC_W=20
    zero = 1'b1;
    tick;
    zero = 1'b0;
    check_angles("sat zero", 0, 0, 0);
    run_stream("sat pos", 20, 32767, -1, 0);
    check_angles("sat pos", 32767, 0, 0);
    run_stream("sat down", 1, -32768, -1, 0);
    check("sat down angle_x", int'(angle_x), 30719);
    run_stream("sat neg", 40, -32768, -1, 0);
    check("sat neg angle_x", int'(angle_x), -32768);
    run_stream("sat up", 1, 16, -1, 0);
    check("sat up angle_x", int'(angle_x), -32767);

    // Async reset between clock edges with a sample in flight
    drive(1'b1, 164, -1, 0);
    tick;
    drive(1'b0, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    check("async rst calibrated", int'(calibrated), 0);
    check("async rst out_valid", int'(out_valid), 0);
    check_angles("async rst", 0, 0, 0);
    tick;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("post-rst out_valid", int'(out_valid), 0);
      check("post-rst calibrated", int'(calibrated), 0);
    end
    check_angles("post-rst", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
